cascaded_modulo_counter: RTL and testbench

- Parametrised successor to the single-stage seconds and limited counters.
- A chain of STAGES modulo counters, each with its own modulus and all sharing one enable, with a same-cycle carry/borrow ripple.
- Adds up/down counting, synchronous parallel load with range checking, per-stage carry outputs and a full-chain wrap flag.
- Sits in the clock/timer datapath: stage 0 is fed by the 1 Hz tick; default configuration is sec/min/hour (60/60/24).

---
 rtl/cascaded_modulo_counter_if.sv | 25 ++
 rtl/cascaded_modulo_counter.sv | 84 ++++++++
 tb/tb_cascaded_modulo_counter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cascaded_modulo_counter_if.sv
// Control and observation bundle for the cascaded modulo counter.
// The master side drives the tick, direction and load inputs; the slave side is the counter itself.
interface cascaded_modulo_counter_if #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned W      = 8
);
  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [STAGES*W-1:0]   load_val;
  logic [STAGES*W-1:0]   count;
  logic [STAGES-1:0]     carry;
  logic                  wrap;
  logic                  load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  count, carry, wrap, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, carry, wrap, load_err
  );
endinterface

// File: rtl/cascaded_modulo_counter.sv
// Chain of per-stage modulo counters with a same-cycle carry/borrow ripple, up/down counting,
// range-checked parallel load and a whole-chain wrap flag (default sec/min/hour = 60/60/24).
module cascaded_modulo_counter #(
  parameter int unsigned         STAGES = 3,
  parameter int unsigned         W      = 8,
  parameter logic [STAGES*W-1:0] MODS   = {8'd24, 8'd60, 8'd60}
) (
  input logic                    clk,
  input logic                    rst,
  cascaded_modulo_counter_if.slave bus
);

  localparam int unsigned NB = STAGES * W;

  // Reject degenerate configurations at elaboration.
  if (STAGES < 1) begin : g_stages_chk
    $error("cascaded_modulo_counter: STAGES must be >= 1");
  end
  for (genvar g = 0; g < STAGES; g++) begin : g_mod_chk
    if (MODS[g*W +: W] < W'(2)) begin : g_bad
      $error("cascaded_modulo_counter: stage modulus must be >= 2");
    end
  end

  logic [STAGES-1:0][W-1:0] mods_a;
  logic [STAGES-1:0][W-1:0] load_a;
  logic [STAGES-1:0][W-1:0] cnt;
  logic [STAGES-1:0][W-1:0] cnt_nxt;
  logic [STAGES-1:0]        adv;
  logic [STAGES-1:0]        term;
  logic [STAGES-1:0]        carry_c;
  logic                     step;
  logic                     bad_any;
  logic                     load_err_q;

  assign mods_a = MODS;
  assign load_a = bus.load_val;

  // Ripple: each stage advances when all lower stages sit at their terminal value.
  always_comb begin
    adv     = '0;
    term    = '0;
    carry_c = '0;
    cnt_nxt = cnt;
    bad_any = 1'b0;
    step    = bus.en & ~bus.load;
    for (int i = 0; i < STAGES; i++) begin
      term[i]    = bus.up_dn ? (cnt[i] == W'(mods_a[i] - W'(1))) : (cnt[i] == '0);
      adv[i]     = step;
      carry_c[i] = adv[i] & term[i] & rst;
      step       = step & term[i];
      if (bus.load) begin
        if (load_a[i] < mods_a[i]) begin
          cnt_nxt[i] = load_a[i];
        end else begin
          cnt_nxt[i] = '0;
          bad_any    = 1'b1;
        end
      end else if (adv[i]) begin
        if (bus.up_dn) begin
          cnt_nxt[i] = term[i] ? '0 : W'(cnt[i] + W'(1));
        end else begin
          cnt_nxt[i] = term[i] ? W'(mods_a[i] - W'(1)) : W'(cnt[i] - W'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      load_err_q <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      load_err_q <= bus.load & bad_any;
    end
  end

  assign bus.count    = NB'(cnt);
  assign bus.carry    = carry_c;
  assign bus.wrap     = carry_c[STAGES-1];
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_cascaded_modulo_counter.sv
// Directed bench for cascaded_modulo_counter: default 60/60/24 chain plus a 6/10 two-stage chain.
module tb_cascaded_modulo_counter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   n_wrap;
  int   wrap_tick;

  cascaded_modulo_counter_if #(.STAGES(3), .W(8)) a_if ();
  cascaded_modulo_counter_if #(.STAGES(2), .W(4)) b_if ();

  cascaded_modulo_counter #(.STAGES(3), .W(8), .MODS({8'd24, 8'd60, 8'd60})) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  cascaded_modulo_counter #(.STAGES(2), .W(4), .MODS({4'd10, 4'd6})) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {8'(h), 8'(m), 8'(s)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_wrap = 0; wrap_tick = 0;
    rst = 1'b0;
    a_if.en = 1'b0; a_if.up_dn = 1'b1; a_if.load = 1'b0; a_if.load_val = '0;
    b_if.en = 1'b0; b_if.up_dn = 1'b1; b_if.load = 1'b0; b_if.load_val = '0;

    #2;
    chk("rst_count", 32'(a_if.count), 32'(0));
    chk("rst_load_err", 32'(a_if.load_err), 32'(0));
    // Down-count at zero would be terminal everywhere; reset must still mask carry.
    a_if.en = 1'b1; a_if.up_dn = 1'b0; #1;
    chk("rst_carry", 32'(a_if.carry), 32'(0));
    chk("rst_wrap", 32'(a_if.wrap), 32'(0));
    a_if.en = 1'b0; a_if.up_dn = 1'b1;
    @(posedge clk); #3; rst = 1'b1;

    // Load 23:59:58 together with en; load wins.
    a_if.load = 1'b1; a_if.load_val = hms(23, 59, 58); a_if.en = 1'b1; #1;
    chk("load_carry", 32'(a_if.carry), 32'(0));
    tick();
    chk("load_235958", 32'(a_if.count), 32'(hms(23, 59, 58)));
    chk("load_err_ok", 32'(a_if.load_err), 32'(0));
    a_if.load = 1'b0; #1;
    chk("c58_carry", 32'(a_if.carry), 32'(0));
    chk("c58_wrap", 32'(a_if.wrap), 32'(0));
    tick();
    chk("up_235959", 32'(a_if.count), 32'(hms(23, 59, 59)));
    chk("up_term_carry", 32'(a_if.carry), 32'(3'b111));
    chk("up_term_wrap", 32'(a_if.wrap), 32'(1));
    tick();
    chk("up_wrap_000000", 32'(a_if.count), 32'(0));

    // Down-count from zero borrows through every stage.
    a_if.up_dn = 1'b0; #1;
    chk("dn_term_carry", 32'(a_if.carry), 32'(3'b111));
    chk("dn_term_wrap", 32'(a_if.wrap), 32'(1));
    tick();
    chk("dn_235959", 32'(a_if.count), 32'(hms(23, 59, 59)));
    chk("dn_59_carry", 32'(a_if.carry), 32'(0));
    tick();
    chk("dn_235958", 32'(a_if.count), 32'(hms(23, 59, 58)));

    // Out-of-range load fields become 0 and flag load_err for one cycle.
    a_if.en = 1'b0; a_if.up_dn = 1'b1; a_if.load = 1'b1; a_if.load_val = hms(25, 60, 10);
    tick();
    chk("bad_load_count", 32'(a_if.count), 32'(hms(0, 0, 10)));
    chk("bad_load_err", 32'(a_if.load_err), 32'(1));
    a_if.load_val = hms(1, 2, 3);
    tick();
    chk("good_load_count", 32'(a_if.count), 32'(hms(1, 2, 3)));
    chk("good_load_err", 32'(a_if.load_err), 32'(0));
    a_if.load_val = hms(30, 0, 0);
    tick();
    chk("bad_hour_err", 32'(a_if.load_err), 32'(1));
    chk("bad_hour_count", 32'(a_if.count), 32'(0));
    a_if.load = 1'b0;
    tick();
    chk("idle_err_clear", 32'(a_if.load_err), 32'(0));
    chk("idle_hold", 32'(a_if.count), 32'(0));

    // load and en together at 00:00:59: no carry, load value taken verbatim.
    a_if.load = 1'b1; a_if.load_val = hms(0, 0, 59);
    tick();
    a_if.load_val = hms(5, 6, 7); a_if.en = 1'b1; #1;
    chk("load_en_carry", 32'(a_if.carry), 32'(0));
    tick();
    chk("load_en_count", 32'(a_if.count), 32'(hms(5, 6, 7)));

    // en pattern 1,0,0,1 from zero.
    a_if.load_val = '0;
    tick();
    a_if.load = 1'b0;
    a_if.en = 1'b1; #1; chk("en1_carry", 32'(a_if.carry), 32'(0)); tick();
    chk("en1_count", 32'(a_if.count), 32'(hms(0, 0, 1)));
    a_if.en = 1'b0; #1; chk("en0a_carry", 32'(a_if.carry), 32'(0)); tick();
    chk("en0a_count", 32'(a_if.count), 32'(hms(0, 0, 1)));
    #1; chk("en0b_carry", 32'(a_if.carry), 32'(0)); tick();
    chk("en0b_count", 32'(a_if.count), 32'(hms(0, 0, 1)));
    a_if.en = 1'b1; #1; chk("en1b_carry", 32'(a_if.carry), 32'(0)); tick();
    chk("en1b_count", 32'(a_if.count), 32'(hms(0, 0, 2)));

    // Asynchronous reset between edges at 12:34:56.
    a_if.en = 1'b0; a_if.load = 1'b1; a_if.load_val = hms(12, 34, 56);
    tick();
    chk("pre_rst_count", 32'(a_if.count), 32'(hms(12, 34, 56)));
    a_if.load = 1'b0; a_if.en = 1'b1; a_if.up_dn = 1'b0;
    #2; rst = 1'b0; #1;
    chk("async_rst_count", 32'(a_if.count), 32'(0));
    chk("async_rst_carry", 32'(a_if.carry), 32'(0));
    chk("async_rst_wrap", 32'(a_if.wrap), 32'(0));
    a_if.up_dn = 1'b1; #1; rst = 1'b1;
    tick();
    chk("post_rst_first", 32'(a_if.count), 32'(hms(0, 0, 1)));

    // Two-stage 6/10 chain: 60 up-ticks, wrap exactly once on tick 60.
    a_if.en = 1'b0;
    b_if.en = 1'b1; b_if.up_dn = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      if (b_if.wrap) begin
        n_wrap++;
        wrap_tick = t;
      end
      tick();
    end
    b_if.en = 1'b0;
    chk("b_wrap_count", 32'(n_wrap), 32'(1));
    chk("b_wrap_tick", 32'(wrap_tick), 32'(60));
    chk("b_final_count", 32'(b_if.count), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
